// File: rtl/irq_ctrl_8.sv
// 8-line interrupt controller with mask, in-service priority
// and an irq/ack/eoi handshake towards the control unit.
module irq_ctrl_8 #(
    parameter logic [7:0] EDGE_LINES = 8'h00
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [7:0] irq_in,
    input  logic       mask_wr,
    input  logic [7:0] mask_data,
    output logic [7:0] mask,
    output logic       irq,
    input  logic       ack,
    output logic [3:0] vector,
    output logic       vector_valid,
    input  logic       eoi,
    output logic [7:0] in_service
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_ACK
    } state_t;

    state_t     r_state;
    logic [7:0] r_irq_q;
    logic [7:0] r_pend;
    logic [7:0] r_mask;
    logic [7:0] r_isv;
    logic [3:0] r_vector;

    logic [7:0] w_pending;
    logic [7:0] w_isv_low;
    logic [7:0] w_hp;
    logic [7:0] w_elig;
    logic [7:0] w_rise;
    logic [7:0] w_ack_set;
    logic [7:0] w_isv_eoi;
    logic [3:0] w_win;
    logic       w_take;

    // Edge lines use the latch, level lines follow the synchronised input.
    assign w_pending = (r_pend & EDGE_LINES) | (r_irq_q & ~EDGE_LINES);

    // Lowest set in-service bit minus one gives the strictly-higher mask;
    // with nothing in service the subtraction wraps to all ones.
    assign w_isv_low = r_isv & (~r_isv + 8'd1);
    assign w_hp      = w_isv_low - 8'd1;
    assign w_elig    = w_pending & ~r_mask & w_hp;

    assign w_rise    = irq_in & ~r_irq_q & EDGE_LINES;
    assign w_take    = (r_state == S_REQ) && ack && (w_win != 4'd0);
    assign w_isv_eoi = eoi ? (r_isv & (r_isv - 8'd1)) : r_isv;

    // Priority encoder: lowest eligible index wins, code = index + 1.
    always_comb begin
        w_win = 4'd0;
        for (int i = 7; i >= 0; i--) begin
            if (w_elig[i]) begin
                w_win = 4'(i + 1);
            end
        end
    end

    // One-hot of the line being acknowledged this cycle.
    always_comb begin
        w_ack_set = 8'h00;
        if (w_take) begin
            w_ack_set[3'(w_win - 4'd1)] = 1'b1;
        end
    end

    // Input sampling register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_irq_q <= 8'h00;
        end else begin
            r_irq_q <= irq_in;
        end
    end

    // Edge latch: a new rising edge beats an ack clear of the same line.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_pend <= 8'h00;
        end else begin
            r_pend <= ((r_pend & ~w_ack_set) | w_rise) & EDGE_LINES;
        end
    end

    // Mask register, all lines masked out of reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_mask <= 8'hFF;
        end else if (mask_wr) begin
            r_mask <= mask_data;
        end
    end

    // In-service bits: eoi clears the lowest one, then ack sets its line.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_isv <= 8'h00;
        end else begin
            r_isv <= w_isv_eoi | w_ack_set;
        end
    end

    // Handshake FSM; the vector is captured at the ack edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= S_IDLE;
            r_vector <= 4'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_win != 4'd0) begin
                        r_state <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (ack) begin
                        r_state  <= S_ACK;
                        r_vector <= w_win;
                    end else if (w_win == 4'd0) begin
                        r_state <= S_IDLE;
                    end
                end
                S_ACK: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign irq          = (r_state == S_REQ);
    assign vector_valid = (r_state == S_ACK);
    assign vector       = r_vector;
    assign mask         = r_mask;
    assign in_service   = r_isv;

endmodule

// File: tb/tb_irq_ctrl_8.sv
// Self-checking bench for irq_ctrl_8: directed scenarios plus
// randomized traffic against a behavioural reference model.
module tb_irq_ctrl_8;

    localparam logic [7:0] EDGE = 8'h5B;

    logic       clk;
    logic       reset_n;
    logic [7:0] irq_in;
    logic       mask_wr;
    logic [7:0] mask_data;
    logic [7:0] mask;
    logic       irq;
    logic       ack;
    logic [3:0] vector;
    logic       vector_valid;
    logic       eoi;
    logic [7:0] in_service;

    int n_vec;
    int n_err;

    // reference model state
    int         m_state;   // 0 idle, 1 requesting, 2 acknowledged
    logic [7:0] m_irqq;
    logic [7:0] m_pend;
    logic [7:0] m_mask;
    logic [7:0] m_isv;
    logic [3:0] m_vec;

    irq_ctrl_8 #(
        .EDGE_LINES(EDGE)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .irq_in      (irq_in),
        .mask_wr     (mask_wr),
        .mask_data   (mask_data),
        .mask        (mask),
        .irq         (irq),
        .ack         (ack),
        .vector      (vector),
        .vector_valid(vector_valid),
        .eoi         (eoi),
        .in_service  (in_service)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_reset();
        m_state = 0;
        m_irqq  = 8'h00;
        m_pend  = 8'h00;
        m_mask  = 8'hFF;
        m_isv   = 8'h00;
        m_vec   = 4'd0;
    endtask

    // Advance one clock; the model computes its next state from the
    // inputs currently applied, and commits it once the edge has passed.
    task automatic step();
        logic [7:0] pv;
        logic [7:0] nisv;
        logic [7:0] npend;
        logic [7:0] nmask;
        logic [3:0] nvec;
        int         li;
        int         win;
        int         ns;
        bit         done;
        for (int i = 0; i < 8; i++)
            pv[i] = EDGE[i] ? m_pend[i] : m_irqq[i];
        li = 8;
        for (int i = 0; i < 8; i++)
            if (m_isv[i] && li == 8) li = i;
        win = 0;
        for (int i = 0; i < 8; i++)
            if (pv[i] && !m_mask[i] && i < li && win == 0) win = i + 1;
        nisv = m_isv;
        if (eoi) begin
            done = 0;
            for (int i = 0; i < 8; i++)
                if (nisv[i] && !done) begin
                    nisv[i] = 1'b0;
                    done = 1;
                end
        end
        npend = m_pend;
        nvec  = m_vec;
        ns    = m_state;
        if (m_state == 0) begin
            if (win != 0) ns = 1;
        end else if (m_state == 1) begin
            if (ack) begin
                ns   = 2;
                nvec = 4'(win);
                if (win != 0) begin
                    nisv[win-1]  = 1'b1;
                    npend[win-1] = 1'b0;
                end
            end else if (win == 0) begin
                ns = 0;
            end
        end else begin
            ns = 0;
        end
        for (int i = 0; i < 8; i++)
            if (EDGE[i] && irq_in[i] && !m_irqq[i]) npend[i] = 1'b1;
        nmask = mask_wr ? mask_data : m_mask;
        @(posedge clk);
        #1;
        m_state = ns;
        m_irqq  = irq_in;
        m_pend  = npend;
        m_mask  = nmask;
        m_isv   = nisv;
        m_vec   = nvec;
    endtask

    task automatic apply_reset();
        reset_n   = 1'b0;
        irq_in    = 8'h00;
        mask_wr   = 1'b0;
        mask_data = 8'h00;
        ack       = 1'b0;
        eoi       = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    task automatic unmask_all();
        mask_wr   = 1'b1;
        mask_data = 8'h00;
        step();
        mask_wr = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        n_vec++;
        if (irq !== 1'b0) begin
            n_err++;
            $display("FAIL rst_irq: got %b want 0", irq);
        end
        n_vec++;
        if (vector !== 4'd0 || vector_valid !== 1'b0) begin
            n_err++;
            $display("FAIL rst_vec: got %0d/%b want 0/0",
                     vector, vector_valid);
        end
        n_vec++;
        if (mask !== 8'hFF || in_service !== 8'h00) begin
            n_err++;
            $display("FAIL rst_regs: got mask %h isv %h want ff 00",
                     mask, in_service);
        end
    endtask

    task automatic test_edge_basic();
        apply_reset();
        unmask_all();
        irq_in = 8'h08;
        step();
        n_vec++;
        if (irq !== 1'b0) begin
            n_err++;
            $display("FAIL t1_early: got irq %b want 0", irq);
        end
        irq_in = 8'h00;
        step();
        n_vec++;
        if (irq !== 1'b1) begin
            n_err++;
            $display("FAIL t1_irq: got irq %b want 1", irq);
        end
        ack = 1'b1;
        step();
        ack = 1'b0;
        n_vec++;
        if (vector !== 4'd4 || vector_valid !== 1'b1 ||
            irq !== 1'b0 || in_service !== 8'h08) begin
            n_err++;
            $display("FAIL t1_ack: got v%0d vv%b irq%b isv %h want 4 1 0 08",
                     vector, vector_valid, irq, in_service);
        end
        step();
        n_vec++;
        if (vector_valid !== 1'b0 || vector !== 4'd4) begin
            n_err++;
            $display("FAIL t1_hold: got v%0d vv%b want 4 0",
                     vector, vector_valid);
        end
    endtask

    task automatic test_simultaneous();
        apply_reset();
        unmask_all();
        irq_in = 8'h0A;
        step();
        step();
        ack = 1'b1;
        step();
        ack = 1'b0;
        n_vec++;
        if (vector !== 4'd2 || in_service !== 8'h02) begin
            n_err++;
            $display("FAIL t2_first: got v%0d isv %h want 2 02",
                     vector, in_service);
        end
        step();
        step();
        n_vec++;
        if (irq !== 1'b0) begin
            n_err++;
            $display("FAIL t2_blocked: got irq %b want 0", irq);
        end
        eoi = 1'b1;
        step();
        eoi = 1'b0;
        step();
        n_vec++;
        if (irq !== 1'b1 || in_service !== 8'h00) begin
            n_err++;
            $display("FAIL t2_reraise: got irq %b isv %h want 1 00",
                     irq, in_service);
        end
        ack = 1'b1;
        step();
        ack = 1'b0;
        n_vec++;
        if (vector !== 4'd4 || in_service !== 8'h08) begin
            n_err++;
            $display("FAIL t2_second: got v%0d isv %h want 4 08",
                     vector, in_service);
        end
    endtask

    task automatic test_preempt();
        apply_reset();
        unmask_all();
        irq_in = 8'h08;
        step();
        irq_in = 8'h00;
        step();
        ack = 1'b1;
        step();
        ack = 1'b0;
        step();
        irq_in = 8'h02;
        step();
        step();
        n_vec++;
        if (irq !== 1'b1) begin
            n_err++;
            $display("FAIL t3_preempt: got irq %b want 1", irq);
        end
        ack = 1'b1;
        step();
        ack = 1'b0;
        n_vec++;
        if (vector !== 4'd2 || in_service !== 8'h0A) begin
            n_err++;
            $display("FAIL t3_nest: got v%0d isv %h want 2 0a",
                     vector, in_service);
        end
        step();
        irq_in = 8'h22;
        step();
        step();
        n_vec++;
        if (irq !== 1'b0) begin
            n_err++;
            $display("FAIL t3_low_wait: got irq %b want 0", irq);
        end
        eoi = 1'b1;
        step();
        eoi = 1'b0;
        step();
        n_vec++;
        if (irq !== 1'b0 || in_service !== 8'h08) begin
            n_err++;
            $display("FAIL t3_one_eoi: got irq %b isv %h want 0 08",
                     irq, in_service);
        end
        eoi = 1'b1;
        step();
        eoi = 1'b0;
        step();
        n_vec++;
        if (irq !== 1'b1 || in_service !== 8'h00) begin
            n_err++;
            $display("FAIL t3_two_eoi: got irq %b isv %h want 1 00",
                     irq, in_service);
        end
        ack = 1'b1;
        step();
        ack = 1'b0;
        n_vec++;
        if (vector !== 4'd6) begin
            n_err++;
            $display("FAIL t3_vec6: got %0d want 6", vector);
        end
    endtask

    task automatic test_level_withdraw();
        apply_reset();
        unmask_all();
        irq_in = 8'h04;
        step();
        step();
        n_vec++;
        if (irq !== 1'b1) begin
            n_err++;
            $display("FAIL t4_irq: got %b want 1", irq);
        end
        irq_in = 8'h00;
        step();
        step();
        n_vec++;
        if (irq !== 1'b0 || vector_valid !== 1'b0) begin
            n_err++;
            $display("FAIL t4_drop: got irq %b vv %b want 0 0",
                     irq, vector_valid);
        end
        irq_in = 8'h04;
        step();
        step();
        irq_in = 8'h00;
        step();
        ack = 1'b1;
        step();
        ack = 1'b0;
        n_vec++;
        if (vector_valid !== 1'b1 || vector !== 4'd0 ||
            in_service !== 8'h00) begin
            n_err++;
            $display("FAIL t4_spurious: got vv%b v%0d isv %h want 1 0 00",
                     vector_valid, vector, in_service);
        end
    endtask

    task automatic test_mask();
        apply_reset();
        irq_in = 8'hFF;
        for (int i = 0; i < 3; i++) begin
            step();
            n_vec++;
            if (irq !== 1'b0) begin
                n_err++;
                $display("FAIL t5_masked: got irq %b want 0", irq);
            end
        end
        mask_wr   = 1'b1;
        mask_data = 8'hEF;
        step();
        mask_wr = 1'b0;
        n_vec++;
        if (mask !== 8'hEF || irq !== 1'b0) begin
            n_err++;
            $display("FAIL t5_maskwr: got mask %h irq %b want ef 0",
                     mask, irq);
        end
        step();
        n_vec++;
        if (irq !== 1'b1) begin
            n_err++;
            $display("FAIL t5_irq: got %b want 1", irq);
        end
        ack = 1'b1;
        step();
        ack = 1'b0;
        n_vec++;
        if (vector !== 4'd5) begin
            n_err++;
            $display("FAIL t5_vec: got %0d want 5", vector);
        end
    endtask

    task automatic test_mid_reset();
        apply_reset();
        unmask_all();
        irq_in = 8'h08;
        step();
        irq_in = 8'h00;
        step();
        ack = 1'b1;
        step();
        ack = 1'b0;
        #2;
        reset_n = 1'b0;
        #1;
        model_reset();
        n_vec++;
        if (irq !== 1'b0 || vector !== 4'd0 || vector_valid !== 1'b0 ||
            mask !== 8'hFF || in_service !== 8'h00) begin
            n_err++;
            $display("FAIL t6_reset: irq%b v%0d vv%b mask %h isv %h",
                     irq, vector, vector_valid, mask, in_service);
        end
        @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    task automatic test_random();
        apply_reset();
        unmask_all();
        for (int c = 0; c < 600; c++) begin
            if ($urandom_range(0, 3) == 0) irq_in = 8'($urandom);
            mask_wr   = ($urandom_range(0, 9) == 0);
            mask_data = 8'($urandom) & 8'($urandom);
            ack       = ($urandom_range(0, 2) == 0);
            eoi       = ($urandom_range(0, 6) == 0);
            step();
            n_vec++;
            if (irq !== (m_state == 1) ||
                vector_valid !== (m_state == 2) ||
                vector !== m_vec || mask !== m_mask ||
                in_service !== m_isv) begin
                n_err++;
                $display("FAIL rnd%0d: irq%b vv%b v%0d m%h isv%h want %b %b %0d %h %h",
                         c, irq, vector_valid, vector, mask, in_service,
                         m_state == 1, m_state == 2, m_vec, m_mask, m_isv);
            end
        end
        ack     = 1'b0;
        eoi     = 1'b0;
        mask_wr = 1'b0;
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        test_reset();
        test_edge_basic();
        test_simultaneous();
        test_preempt();
        test_level_withdraw();
        test_mask();
        test_mid_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
